uart_rx_oversample: RTL and testbench

//  16x-oversampling UART receiver: the serial-input stage feeding the byte path toward the transmitter.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tick_gen.sv | 36 +++
 rtl/uart_rx_oversample.sv | 125 ++++++++++++
 tb/tb_uart_rx_oversample.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int unsigned DATA_BITS = 8;

  // Clocks per sample tick, truncated toward zero.
  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_n;

  always_comb begin
    count_n = count + CW'(1);
    if (count == CW'(TICK_DIV - 1)) count_n = '0;
  end

  // tick is registered alongside count so it is high exactly when count == TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_n;
      tick  <= (count_n == CW'(TICK_DIV - 1));
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling 8N1 UART receiver with mid-bit sampling and framing-error strobe.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned MID = OVERSAMPLE / 2 - 1;

  logic tick;

  uart_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [1:0] sync;
  logic       rx_s;
  assign rx_s = sync[1];

  uart_rx_state_t       state, state_n;
  logic [SW-1:0]        scnt, scnt_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [7:0]           rx_data_n;
  logic                 rx_valid_n, frame_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      state     <= IDLE;
      scnt      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      state     <= state_n;
      scnt      <= scnt_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      busy      <= (state_n != IDLE);
    end
  end

  // Next-state and datapath; everything advances only on sample ticks.
  always_comb begin
    state_n     = state;
    scnt_n      = scnt;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            scnt_n  = '0;
          end
        end
        START: begin
          // Re-zeroing at mid start bit aligns later wraps to mid-bit.
          if (scnt == SW'(MID)) begin
            scnt_n   = '0;
            bitcnt_n = '0;
            state_n  = rx_s ? IDLE : DATA;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
        DATA: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_n   = '0;
            shreg_n  = {rx_s, shreg[DATA_BITS-1:1]};
            bitcnt_n = bitcnt + BW'(1);
            if (bitcnt == BW'(DATA_BITS - 1)) state_n = STOP;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
        STOP: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_n  = '0;
            state_n = IDLE;
            if (rx_s) begin
              rx_data_n  = shreg;
              rx_valid_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample at 160 clk per bit.
module tb_uart_rx_oversample;

  localparam int BIT_CLK = 160;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   overlap = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  uart_rx_oversample #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe as an observed event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && frame_err) overlap++;
      if (rx_valid)  obs_q.push_back('{err: 1'b0, data: rx_data, cyc: cyc});
      if (frame_err) obs_q.push_back('{err: 1'b1, data: 8'h00, cyc: cyc});
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [7:0] v;
    v = d;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    last_good = 8'h00;
  endtask

  task automatic test_idle();
    int busy_hi;
    busy_hi = 0;
    for (int i = 0; i < 10_000; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
    end
    total++; if (busy_hi != 0) begin bad++; $display("FAIL idle_busy got=%0d busy cycles want=0", busy_hi); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL idle_strobes got=%0d want=0", obs_q.size()); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL idle_rx_data got=%h want=00", rx_data); end
  endtask

  task automatic test_single();
    ev_t e, o;
    bit ok;
    exp_q.push_back('{err: 1'b0, data: 8'h54, cyc: 0});
    send_frame(8'h54, 1'b1);
    last_good = 8'h54;
    wait_obs(1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d events want=1", obs_q.size()); end
    repeat (2 * BIT_CLK) @(negedge clk);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o.err !== e.err) begin bad++; $display("FAIL single_kind got_err=%b want_err=%b", o.err, e.err); end
      total++; if (o.data !== e.data) begin bad++; $display("FAIL single_data got=%h want=%h", o.data, e.data); end
    end
    total++; if (rx_data !== last_good) begin bad++; $display("FAIL single_hold got=%h want=%h", rx_data, last_good); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int t[2];
    bit ok;
    exp_q.push_back('{err: 1'b0, data: 8'h41, cyc: 0});
    send_frame(8'h41, 1'b1);
    exp_q.push_back('{err: 1'b0, data: 8'h4D, cyc: 0});
    send_frame(8'h4D, 1'b1);
    last_good = 8'h4D;
    wait_obs(2, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d events want=2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      t[i] = 0;
      if (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        t[i] = o.cyc;
        total++; if (o.err !== e.err) begin bad++; $display("FAIL b2b_kind%0d got_err=%b want_err=%b", i, o.err, e.err); end
        total++; if (o.data !== e.data) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, o.data, e.data); end
      end
    end
    total++;
    if ((t[1] - t[0]) < 10 * BIT_CLK - 10 || (t[1] - t[0]) > 10 * BIT_CLK + 10) begin
      bad++; $display("FAIL b2b_gap got=%0d want=%0d+-10", t[1] - t[0], 10 * BIT_CLK);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b want=1", busy); end
    repeat (300) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b want=0", busy); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL glitch_strobes got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    ev_t e, o;
    bit ok;
    exp_q.push_back('{err: 1'b1, data: 8'h00, cyc: 0});
    send_frame(8'h49, 1'b0);
    wait_obs(1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL ferr_timeout got=%0d events want=1", obs_q.size()); end
    total++; if (rx_data !== last_good) begin bad++; $display("FAIL ferr_hold got=%h want=%h", rx_data, last_good); end
    repeat (2 * BIT_CLK) @(negedge clk);
    exp_q.push_back('{err: 1'b0, data: 8'h4D, cyc: 0});
    send_frame(8'h4D, 1'b1);
    last_good = 8'h4D;
    wait_obs(2, 400, ok);
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL ferr_count got=%0d want=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o.err !== e.err) begin bad++; $display("FAIL ferr_kind got_err=%b want_err=%b", o.err, e.err); end
      if (!e.err) begin
        total++; if (o.data !== e.data) begin bad++; $display("FAIL ferr_data got=%h want=%h", o.data, e.data); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    ev_t o;
    bit ok;
    v = 8'h54;
    repeat (BIT_CLK) @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v[i]);
    rx = v[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_rx_data got=%h want=00", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_strobes got=%0d want=0", obs_q.size()); end
    send_frame(8'h41, 1'b1);
    last_good = 8'h41;
    wait_obs(1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=%0d events want=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      total++; if (o.err !== 1'b0 || o.data !== 8'h41) begin
        bad++; $display("FAIL rstmid_data got=%h err=%b want=41 err=0", o.data, o.err);
      end
    end
    total++; if (rx_data !== last_good) begin bad++; $display("FAIL rstmid_hold got=%h want=%h", rx_data, last_good); end
    obs_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    total++; if (overlap != 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
